// File: rtl/writeback_stage_pkg.sv
// Shared encodings for the writeback stage: rd sources, load funct3 codes,
// FSM states and the stage-5 pipeline register bundle.
package writeback_stage_pkg;

  localparam logic [1:0] RD_SRC_ALU  = 2'd0;
  localparam logic [1:0] RD_SRC_LOAD = 2'd1;
  localparam logic [1:0] RD_SRC_CSR  = 2'd2;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

  localparam logic [4:0] ZERO_REG_ADDR = 5'd0;

  typedef enum logic {
    WB_IDLE      = 1'b0,
    WB_LOAD_WAIT = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic        rd_w_en;
    logic [31:0] data;
    logic        fault;
  } wb_t;

endpackage

// File: rtl/writeback_stage_load_align.sv
// Load data alignment: picks the byte/halfword lane from the bus word
// and sign- or zero-extends it according to funct3.
module load_align
  import writeback_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = 8'h00;
    case (addr_lo)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data = rdata;
    case (funct3)
      FUNCT3_LB:  data = {{24{b[7]}}, b};
      FUNCT3_LH:  data = {{16{h[15]}}, h};
      FUNCT3_LBU: data = {24'h0, b};
      FUNCT3_LHU: data = {16'h0, h};
      default:    data = rdata;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Pipeline stage 5: retires the stage-4 instruction, selects its rd value,
// drives the register-file write port and counts retired instructions.
module writeback_stage
  import writeback_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_flush,
  input  logic [4:0]  mem_rd,
  input  logic        mem_rd_w_en,
  input  logic [1:0]  mem_rd_src,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_csr_rdata,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_ack,
  input  logic        dbus_err,
  output logic        mem_stall,
  output logic        writeback_en,
  output logic [4:0]  wb_rd,
  output logic        wb_rd_w_en,
  output logic [31:0] writeback_rd_data,
  output logic        rf_w_en,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        load_fault,
  output logic [63:0] instret
);

  wb_state_e   state;
  wb_t         wb;
  logic [31:0] load_data;
  logic [31:0] sel_data;
  logic        is_load;
  logic        capture;
  logic        fault;

  load_align u_align (
    .rdata   (dbus_rdata),
    .addr_lo (mem_alu_result[1:0]),
    .funct3  (mem_funct3),
    .data    (load_data)
  );

  assign is_load = (mem_rd_src == RD_SRC_LOAD);
  assign fault   = is_load & dbus_err;

  // In WAIT stage 4 is frozen, so its inputs still describe the load.
  always_comb begin
    capture   = 1'b0;
    mem_stall = 1'b0;
    if (!rst && !mem_flush) begin
      unique case (state)
        WB_IDLE: begin
          capture   = mem_valid & (!is_load | dbus_ack);
          mem_stall = mem_valid & is_load & !dbus_ack;
        end
        WB_LOAD_WAIT: begin
          capture   = dbus_ack;
          mem_stall = !dbus_ack;
        end
      endcase
    end
  end

  always_comb begin
    sel_data = mem_alu_result;
    case (mem_rd_src)
      RD_SRC_LOAD: sel_data = load_data;
      RD_SRC_CSR:  sel_data = mem_csr_rdata;
      default:     sel_data = mem_alu_result;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= WB_IDLE;
      wb      <= '0;
      instret <= 64'd0;
    end else begin
      if (mem_flush || capture) begin
        state <= WB_IDLE;
      end else if (state == WB_IDLE && mem_stall) begin
        state <= WB_LOAD_WAIT;
      end
      wb.valid <= capture;
      if (capture) begin
        wb.rd      <= mem_rd;
        wb.rd_w_en <= mem_rd_w_en & (mem_rd != ZERO_REG_ADDR) & !fault;
        wb.data    <= sel_data;
        wb.fault   <= fault;
        instret    <= instret + 64'd1;
      end else begin
        wb.rd_w_en <= 1'b0;
        wb.fault   <= 1'b0;
      end
    end
  end

  assign writeback_en      = wb.valid;
  assign wb_rd             = wb.rd;
  assign wb_rd_w_en        = wb.rd_w_en;
  assign writeback_rd_data = wb.data;
  assign load_fault        = wb.fault;
  assign rf_w_en           = wb.valid & wb.rd_w_en;
  assign rf_waddr          = wb.rd;
  assign rf_wdata          = wb.data;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: single-cycle vector table plus
// hand sequences for load stalls, flush and reset mid-load.
module tb_writeback_stage;
  import writeback_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_flush, mem_rd_w_en;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_rd_src;
  logic [31:0] mem_alu_result, mem_csr_rdata, dbus_rdata;
  logic [2:0]  mem_funct3;
  logic        dbus_ack, dbus_err;
  logic        mem_stall, writeback_en, wb_rd_w_en, rf_w_en, load_fault;
  logic [4:0]  wb_rd, rf_waddr;
  logic [31:0] writeback_rd_data, rf_wdata;
  logic [63:0] instret;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_ret = 64'd0;

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk               (clk),
    .rst               (rst),
    .mem_valid         (mem_valid),
    .mem_flush         (mem_flush),
    .mem_rd            (mem_rd),
    .mem_rd_w_en       (mem_rd_w_en),
    .mem_rd_src        (mem_rd_src),
    .mem_alu_result    (mem_alu_result),
    .mem_csr_rdata     (mem_csr_rdata),
    .mem_funct3        (mem_funct3),
    .dbus_rdata        (dbus_rdata),
    .dbus_ack          (dbus_ack),
    .dbus_err          (dbus_err),
    .mem_stall         (mem_stall),
    .writeback_en      (writeback_en),
    .wb_rd             (wb_rd),
    .wb_rd_w_en        (wb_rd_w_en),
    .writeback_rd_data (writeback_rd_data),
    .rf_w_en           (rf_w_en),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .load_fault        (load_fault),
    .instret           (instret)
  );

  typedef struct {
    logic [1:0]  src;
    logic [4:0]  rd;
    logic        w_en;
    logic [31:0] alu;
    logic [31:0] csr;
    logic [2:0]  f3;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] exp_data;
    logic        exp_wen;
    logic        exp_fault;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    mem_valid = 0; mem_flush = 0; mem_rd = 0; mem_rd_w_en = 0;
    mem_rd_src = RD_SRC_ALU; mem_alu_result = 0; mem_csr_rdata = 0;
    mem_funct3 = 0; dbus_rdata = 0; dbus_ack = 0; dbus_err = 0;
  endtask

  task automatic load_in(input logic [4:0] rd, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rdata);
    mem_valid = 1; mem_rd = rd; mem_rd_w_en = 1;
    mem_rd_src = RD_SRC_LOAD; mem_funct3 = f3;
    mem_alu_result = addr; dbus_rdata = rdata;
  endtask

  initial begin
    vecs[0]  = '{RD_SRC_ALU,  5'd5, 1'b1, 32'h1234_5678, 32'h0, FUNCT3_LW,
                 32'h0, 1'b0, 32'h1234_5678, 1'b1, 1'b0};
    vecs[1]  = '{RD_SRC_CSR,  5'd7, 1'b1, 32'h0000_0001, 32'hCAFE_BABE,
                 FUNCT3_LW, 32'h0, 1'b0, 32'hCAFE_BABE, 1'b1, 1'b0};
    vecs[2]  = '{RD_SRC_LOAD, 5'd8, 1'b1, 32'h0000_1002, 32'h0, FUNCT3_LHU,
                 32'hBEEF_0000, 1'b0, 32'h0000_BEEF, 1'b1, 1'b0};
    vecs[3]  = '{RD_SRC_LOAD, 5'd9, 1'b1, 32'h0000_1000, 32'h0, FUNCT3_LW,
                 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0};
    vecs[4]  = '{RD_SRC_LOAD, 5'd10, 1'b1, 32'h0000_0001, 32'h0, FUNCT3_LB,
                 32'h0000_8000, 1'b0, 32'hFFFF_FF80, 1'b1, 1'b0};
    vecs[5]  = '{RD_SRC_LOAD, 5'd11, 1'b1, 32'h0000_0002, 32'h0, FUNCT3_LBU,
                 32'h00AB_0000, 1'b0, 32'h0000_00AB, 1'b1, 1'b0};
    vecs[6]  = '{RD_SRC_LOAD, 5'd12, 1'b1, 32'h0000_0000, 32'h0, FUNCT3_LH,
                 32'h1234_F00D, 1'b0, 32'hFFFF_F00D, 1'b1, 1'b0};
    vecs[7]  = '{RD_SRC_LOAD, 5'd13, 1'b1, 32'h0000_0002, 32'h0, FUNCT3_LH,
                 32'h7FFF_0000, 1'b0, 32'h0000_7FFF, 1'b1, 1'b0};
    vecs[8]  = '{RD_SRC_ALU,  5'd0, 1'b1, 32'h0000_0055, 32'h0, FUNCT3_LW,
                 32'h0, 1'b0, 32'h0000_0055, 1'b0, 1'b0};
    vecs[9]  = '{RD_SRC_ALU,  5'd9, 1'b0, 32'h0000_0077, 32'h0, FUNCT3_LW,
                 32'h0, 1'b0, 32'h0000_0077, 1'b0, 1'b0};
    vecs[10] = '{RD_SRC_LOAD, 5'd3, 1'b1, 32'h0000_0000, 32'h0, FUNCT3_LW,
                 32'h1111_2222, 1'b1, 32'h1111_2222, 1'b0, 1'b1};

    idle_in();
    rst = 1;
    #1;
    chk("rst_stall", mem_stall, 0);
    chk("rst_wben", writeback_en, 0);
    chk("rst_rfwen", rf_w_en, 0);
    chk("rst_data", rf_wdata, 0);
    chk("rst_instret", instret, 0);
    step();
    step();
    rst = 0;
    step();

    for (int i = 0; i < 11; i++) begin
      mem_valid = 1; mem_rd = vecs[i].rd; mem_rd_w_en = vecs[i].w_en;
      mem_rd_src = vecs[i].src; mem_alu_result = vecs[i].alu;
      mem_csr_rdata = vecs[i].csr; mem_funct3 = vecs[i].f3;
      dbus_rdata = vecs[i].rdata;
      dbus_ack = (vecs[i].src == RD_SRC_LOAD);
      dbus_err = vecs[i].err;
      #1;
      chk($sformatf("v%0d_stall", i), mem_stall, 0);
      step();
      exp_ret++;
      idle_in();
      chk($sformatf("v%0d_wben", i), writeback_en, 1);
      chk($sformatf("v%0d_data", i), rf_wdata, vecs[i].exp_data);
      chk($sformatf("v%0d_wbdata", i), writeback_rd_data, vecs[i].exp_data);
      chk($sformatf("v%0d_rd", i), rf_waddr, vecs[i].rd);
      chk($sformatf("v%0d_wbwen", i), wb_rd_w_en, vecs[i].exp_wen);
      chk($sformatf("v%0d_rfwen", i), rf_w_en, vecs[i].exp_wen);
      chk($sformatf("v%0d_fault", i), load_fault, vecs[i].exp_fault);
      chk($sformatf("v%0d_instret", i), instret, exp_ret);
      step();
      chk($sformatf("v%0d_bub_wben", i), writeback_en, 0);
      chk($sformatf("v%0d_bub_rfwen", i), rf_w_en, 0);
      chk($sformatf("v%0d_bub_fault", i), load_fault, 0);
      chk($sformatf("v%0d_bub_hold", i), rf_wdata, vecs[i].exp_data);
    end

    // LB lane 3 with the ack arriving in the fourth cycle
    load_in(5'd14, FUNCT3_LB, 32'h0000_2003, 32'h80FF_FFFF);
    #1;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("lb_stall%0d", c), mem_stall, 1);
      step();
      chk($sformatf("lb_bubble%0d", c), writeback_en, 0);
    end
    dbus_ack = 1;
    #1;
    chk("lb_ack_stall", mem_stall, 0);
    step();
    exp_ret++;
    idle_in();
    chk("lb_wben", writeback_en, 1);
    chk("lb_data", rf_wdata, 32'hFFFF_FF80);
    chk("lb_rfwen", rf_w_en, 1);
    chk("lb_instret", instret, exp_ret);
    step();

    // flush with simultaneous ack while waiting
    load_in(5'd15, FUNCT3_LW, 32'h0, 32'h5555_AAAA);
    step();
    chk("fl_wait_stall", mem_stall, 1);
    dbus_ack = 1; mem_flush = 1;
    #1;
    chk("fl_stall", mem_stall, 0);
    step();
    idle_in();
    chk("fl_wben", writeback_en, 0);
    chk("fl_next_stall", mem_stall, 0);
    chk("fl_instret", instret, exp_ret);
    dbus_ack = 1;
    step();
    dbus_ack = 0;
    chk("fl_idle_ack_ignored", writeback_en, 0);
    chk("fl_idle_instret", instret, exp_ret);

    // flush of a plain ALU op in idle
    mem_valid = 1; mem_rd = 5'd4; mem_rd_w_en = 1;
    mem_alu_result = 32'h0BAD_0BAD; mem_flush = 1;
    step();
    idle_in();
    chk("fl_alu_wben", writeback_en, 0);
    chk("fl_alu_instret", instret, exp_ret);

    // reset while a load is outstanding
    mem_valid = 1; mem_rd = 5'd6; mem_rd_w_en = 1;
    mem_alu_result = 32'h0000_00C3;
    step();
    exp_ret++;
    chk("pre_rst_wben", writeback_en, 1);
    load_in(5'd16, FUNCT3_LW, 32'h0, 32'h9999_9999);
    step();
    chk("pre_rst_stall", mem_stall, 1);
    rst = 1;
    #1;
    chk("mid_rst_stall", mem_stall, 0);
    chk("mid_rst_wben", writeback_en, 0);
    chk("mid_rst_data", rf_wdata, 0);
    chk("mid_rst_rd", wb_rd, 0);
    chk("mid_rst_instret", instret, 0);
    step();
    idle_in();
    rst = 0;
    dbus_ack = 1;
    step();
    dbus_ack = 0;
    chk("post_rst_wben", writeback_en, 0);
    chk("post_rst_rfwen", rf_w_en, 0);
    chk("post_rst_instret", instret, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
